pat_source: RTL and testbench
=============================

# pat_source

Hardware stimulus generator that drives the primary-input vector of a gate-level device under fault simulation, such as the `{a, ctl}` bus of a single-switch test cell. It sits directly upstream of the DUT input bus and replaces a software pattern feed. On `start` it emits an exhaustive counting sweep, a pseudo-random LFSR sweep, or both in sequence, over a valid/ready handshake. It counts accepted patterns for the downstream response checker.

## Interface
- `WIDTH`, 2 — pattern width in bits (DUT primary inputs); legal range 2..16.
- `RAND_COUNT`, 16 — number of LFSR patterns emitted in the random phase; legal range 1..65535.
- `SEED`, 1 — LFSR seed (WIDTH bits); a value of 0 is replaced by 1.
- `TAPS`, 2'b11 — Galois feedback mask (WIDTH bits). Default is x^2+x+1, maximal for WIDTH=2.

Ports:
- `clk` in 1 — single clock; all logic on the rising edge.
- `rst_n` in 1 — reset, synchronous, active-low.
- `start` in 1 — one-cycle request to begin a run; honoured only in IDLE or DONE.
- `exh_en` in 1 — include the exhaustive phase; sampled with `start`.
- `rnd_en` in 1 — include the random phase; sampled with `start`.
- `pat` out WIDTH — current pattern; drives the DUT input bus.
- `pat_valid` out 1 — `pat` holds a pattern awaiting acceptance.
- `pat_ready` in 1 — consumer accepts `pat` when `pat_valid & pat_ready`.
- `busy` out 1 — high in the EXH and RND states.
- `done` out 1 — high in the DONE state; held until the next `start`.
- `pat_count` out 16 — accepted-pattern count; saturates at 16'hFFFF.

## Operation
- States: IDLE, EXH, RND, DONE.
- Reset (`rst_n`=0 at an edge) forces IDLE from any state, including mid-run. Output values in reset:
  - `pat`=0
  - `pat_valid`=0
  - `busy`=0
  - `done`=0
  - `pat_count`=0
  - LFSR register = effective seed
- IDLE/DONE + `start`:
  - Latch `exh_en` and `rnd_en`; clear `pat_count`; load the LFSR with the seed; clear the exhaustive counter.
  - Next state: EXH if `exh_en`, else RND if `rnd_en`, else DONE.
- `start` while busy is ignored; the latched enables stay unchanged.
- EXH:
  - `pat` = counter, running 0 .. 2^WIDTH−1.
  - Each accept increments the counter.
  - The accept of the value 2^WIDTH−1 moves to RND if `rnd_en`, else DONE.
- RND:
  - `pat` = LFSR state.
  - Each accept steps the LFSR: lsb=s[0]; s=s>>1; if lsb, s^=TAPS.
  - An internal counter tracks accepts; the RAND_COUNT-th accept moves to DONE.
- DONE: `pat_valid`=0, `done`=1, `pat` holds the last emitted value.
- `pat_count` increments on every accept in any state and saturates at 16'hFFFF with no wrap.
- `pat` must stay stable while `pat_valid & ~pat_ready`. `pat_valid` is never withdrawn before acceptance, except by reset.
- The LFSR never reaches zero with a nonzero seed and a valid TAPS. A non-maximal TAPS is the user's responsibility; the block does not check it.

## Timing
- All outputs are registered; there is no combinational path from `pat_ready` to `pat` or `pat_valid`.
- `start` sampled at edge t → `busy`=1 and `pat_valid`=1 with the first pattern after edge t.
- With `pat_ready` held high, one pattern is emitted per cycle and there is no bubble at the EXH→RND transition.
- Final accept at edge t → `pat_valid`=0, `busy`=0, `done`=1 after edge t. `pat_count` holds its final value.
- Both enables low: `done`=1 one cycle after `start`; `pat_valid` never rises.
- `start` in DONE at edge t → `done`=0 after edge t and a new run begins.
- Run length: (`exh_en` ? 2^WIDTH : 0) + (`rnd_en` ? RAND_COUNT : 0) accepts.

## Test plan
- **Exhaustive only:** WIDTH=2, `exh_en`=1, `rnd_en`=0, `pat_ready`=1 → `pat` = 0,1,2,3 on 4 consecutive cycles. Then `done`=1, `pat_count`=4.
- **Both phases:** WIDTH=2, SEED=1, TAPS=11, RAND_COUNT=4, both enables high → `pat` = 0,1,2,3,1,3,2,1 with no gap; `pat_count`=8; `done`=1.
- **Backpressure:** toggle `pat_ready` 1,0,0,1,... → `pat` is unchanged across stalled cycles, no pattern is skipped or duplicated, and the final `pat_count` equals the run length.
- **Reset mid-run:** drive `rst_n`=0 at the third accept of the EXH phase → next cycle all outputs are 0 and the state is IDLE. A subsequent `start` restarts at `pat`=0.
- **Ignored start and empty run:**
  - Pulse `start` while busy → the sequence is unaffected.
  - `start` with both enables 0 → `done`=1 next cycle, `pat_valid` stays 0, `pat_count`=0.
- **Zero seed:** SEED=0, random-only run → the first `pat` is 1 and the LFSR never emits 0.

Source files
------------

// File: rtl/pat_source.sv
// Stimulus generator for gate-level fault simulation: emits an exhaustive
// counting sweep and/or a Galois-LFSR sweep over a valid/ready handshake.
module pat_source #(
    parameter int                WIDTH      = 2,
    parameter int                RAND_COUNT = 16,
    parameter logic [WIDTH-1:0]  SEED       = WIDTH'(1),
    parameter logic [WIDTH-1:0]  TAPS       = WIDTH'(2'b11)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             exh_en,
    input  logic             rnd_en,
    output logic [WIDTH-1:0] pat,
    output logic             pat_valid,
    input  logic             pat_ready,
    output logic             busy,
    output logic             done,
    output logic [15:0]      pat_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXH  = 2'd1,
        RND  = 2'd2,
        DONE = 2'd3
    } state_t;

    // An all-zero seed would lock the LFSR at zero, so it is replaced by 1.
    localparam logic [WIDTH-1:0] SEED_EFF = (SEED == '0) ? WIDTH'(1) : SEED;
    localparam logic [WIDTH-1:0] EXH_LAST = '1;
    localparam logic [15:0]      RND_LAST = 16'(RAND_COUNT - 1);

    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
        logic [WIDTH-1:0] n;
        n = s >> 1;
        if (s[0]) begin
            n = n ^ TAPS;
        end
        return n;
    endfunction

    state_t           state_q, state_d;
    logic             rnd_en_q, rnd_en_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic [WIDTH-1:0] exh_cnt_q, exh_cnt_d;
    logic [WIDTH-1:0] lfsr_q, lfsr_d;
    logic [15:0]      rnd_cnt_q, rnd_cnt_d;
    logic [15:0]      pat_count_q, pat_count_d;
    logic             accept;
    logic [WIDTH-1:0] lfsr_next;

    assign busy      = (state_q == EXH) || (state_q == RND);
    assign pat_valid = busy;
    assign done      = (state_q == DONE);
    assign pat       = pat_q;
    assign pat_count = pat_count_q;
    assign accept    = pat_valid && pat_ready;
    assign lfsr_next = lfsr_step(lfsr_q);

    always_comb begin
        state_d     = state_q;
        rnd_en_d    = rnd_en_q;
        pat_d       = pat_q;
        exh_cnt_d   = exh_cnt_q;
        lfsr_d      = lfsr_q;
        rnd_cnt_d   = rnd_cnt_q;
        pat_count_d = pat_count_q;

        if (accept && (pat_count_q != 16'hFFFF)) begin
            pat_count_d = pat_count_q + 16'd1;
        end

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    rnd_en_d    = rnd_en;
                    pat_count_d = '0;
                    lfsr_d      = SEED_EFF;
                    exh_cnt_d   = '0;
                    rnd_cnt_d   = '0;
                    if (exh_en) begin
                        state_d = EXH;
                        pat_d   = '0;
                    end else if (rnd_en) begin
                        state_d = RND;
                        pat_d   = SEED_EFF;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            EXH: begin
                if (accept) begin
                    if (exh_cnt_q == EXH_LAST) begin
                        // The LFSR still holds the seed, so RND starts with no bubble.
                        if (rnd_en_q) begin
                            state_d = RND;
                            pat_d   = lfsr_q;
                        end else begin
                            state_d = DONE;
                        end
                    end else begin
                        exh_cnt_d = exh_cnt_q + WIDTH'(1);
                        pat_d     = exh_cnt_q + WIDTH'(1);
                    end
                end
            end
            RND: begin
                if (accept) begin
                    lfsr_d = lfsr_next;
                    if (rnd_cnt_q == RND_LAST) begin
                        state_d = DONE;
                    end else begin
                        rnd_cnt_d = rnd_cnt_q + 16'd1;
                        pat_d     = lfsr_next;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rnd_en_q    <= 1'b0;
            pat_q       <= '0;
            exh_cnt_q   <= '0;
            lfsr_q      <= SEED_EFF;
            rnd_cnt_q   <= '0;
            pat_count_q <= '0;
        end else begin
            state_q     <= state_d;
            rnd_en_q    <= rnd_en_d;
            pat_q       <= pat_d;
            exh_cnt_q   <= exh_cnt_d;
            lfsr_q      <= lfsr_d;
            rnd_cnt_q   <= rnd_cnt_d;
            pat_count_q <= pat_count_d;
        end
    end

endmodule

// File: tb/tb_pat_source.sv
// Directed bench for pat_source: sweeps, backpressure, reset mid-run,
// ignored start, empty run and zero-seed substitution.
module tb_pat_source;

    logic        clk = 1'b0;
    logic        rst_n, start, exh_en, rnd_en, pat_ready;
    logic [1:0]  pat;
    logic        pat_valid, busy, done;
    logic [15:0] pat_count;

    logic        z_start, z_exh_en, z_rnd_en, z_ready;
    logic [1:0]  z_pat;
    logic        z_valid, z_busy, z_done;
    logic [15:0] z_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pat_source #(.WIDTH(2), .RAND_COUNT(4), .SEED(2'd1), .TAPS(2'b11)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .exh_en(exh_en), .rnd_en(rnd_en),
        .pat(pat), .pat_valid(pat_valid), .pat_ready(pat_ready),
        .busy(busy), .done(done), .pat_count(pat_count)
    );

    pat_source #(.WIDTH(2), .RAND_COUNT(6), .SEED(2'd0), .TAPS(2'b11)) u_zseed (
        .clk(clk), .rst_n(rst_n), .start(z_start), .exh_en(z_exh_en), .rnd_en(z_rnd_en),
        .pat(z_pat), .pat_valid(z_valid), .pat_ready(z_ready),
        .busy(z_busy), .done(z_done), .pat_count(z_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [1:0] both_seq [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd3, 2'd2, 2'd1};
    logic [1:0] zs_seq   [6] = '{2'd1, 2'd3, 2'd2, 2'd1, 2'd3, 2'd2};

    initial begin
        int idx;
        int cyc;
        rst_n = 1'b0; start = 1'b0; exh_en = 1'b0; rnd_en = 1'b0; pat_ready = 1'b0;
        z_start = 1'b0; z_exh_en = 1'b0; z_rnd_en = 1'b0; z_ready = 1'b0;
        tick();
        tick();
        chk("rst_pat", pat, 0);
        chk("rst_valid", pat_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_count", pat_count, 0);
        rst_n = 1'b1;
        tick();

        // Exhaustive only
        start = 1'b1; exh_en = 1'b1; rnd_en = 1'b0; pat_ready = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("exh_pat", pat, i);
            chk("exh_valid", pat_valid, 1);
            chk("exh_busy", busy, 1);
            tick();
        end
        chk("exh_done", done, 1);
        chk("exh_valid_end", pat_valid, 0);
        chk("exh_busy_end", busy, 0);
        chk("exh_count", pat_count, 4);
        chk("exh_hold_pat", pat, 3);

        // Both phases, with a start pulse (and changed enables) mid-run
        start = 1'b1; exh_en = 1'b1; rnd_en = 1'b1;
        tick();
        start = 1'b0;
        chk("both_done_clr", done, 0);
        for (int i = 0; i < 8; i++) begin
            start = (i == 2);
            if (i == 2) begin
                exh_en = 1'b0; rnd_en = 1'b0;
            end
            chk("both_pat", pat, both_seq[i]);
            chk("both_valid", pat_valid, 1);
            tick();
        end
        start = 1'b0;
        chk("both_done", done, 1);
        chk("both_count", pat_count, 8);
        chk("both_valid_end", pat_valid, 0);

        // Backpressure: ready 1,0,0 repeating
        start = 1'b1; exh_en = 1'b1; rnd_en = 1'b1;
        tick();
        start = 1'b0;
        idx = 0;
        cyc = 0;
        while (idx < 8 && cyc < 100) begin
            pat_ready = ((cyc % 3) == 0);
            chk("bp_pat", pat, both_seq[idx]);
            chk("bp_valid", pat_valid, 1);
            tick();
            if (pat_ready) idx++;
            cyc++;
        end
        chk("bp_complete", idx, 8);
        pat_ready = 1'b1;
        chk("bp_done", done, 1);
        chk("bp_count", pat_count, 8);

        // Reset asserted on the third EXH accept
        start = 1'b1; exh_en = 1'b1; rnd_en = 1'b0;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("mr_pat_before", pat, 2);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mr_pat", pat, 0);
        chk("mr_valid", pat_valid, 0);
        chk("mr_busy", busy, 0);
        chk("mr_done", done, 0);
        chk("mr_count", pat_count, 0);
        tick();
        chk("mr_idle_valid", pat_valid, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("mr_restart_pat", pat, 0);
        chk("mr_restart_valid", pat_valid, 1);
        for (int i = 0; i < 4; i++) tick();
        chk("mr_rerun_done", done, 1);
        chk("mr_rerun_count", pat_count, 4);

        // Empty run
        start = 1'b1; exh_en = 1'b0; rnd_en = 1'b0;
        tick();
        start = 1'b0;
        chk("empty_done", done, 1);
        chk("empty_valid", pat_valid, 0);
        chk("empty_busy", busy, 0);
        chk("empty_count", pat_count, 0);
        tick();
        chk("empty_valid_later", pat_valid, 0);

        // Zero seed, random-only
        z_start = 1'b1; z_exh_en = 1'b0; z_rnd_en = 1'b1; z_ready = 1'b1;
        tick();
        z_start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("zs_pat", z_pat, zs_seq[i]);
            chk("zs_valid", z_valid, 1);
            tick();
        end
        chk("zs_done", z_done, 1);
        chk("zs_count", z_count, 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
